// File: rtl/intr_arbiter_if.sv
// Interrupt arbiter bus: source lines, masks and CPU claim/EOI handshake.
// The master side is the system/CPU; the slave side is the arbiter.
interface intr_arbiter_if #(
    parameter int NUM_SRC = 16
);
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] en_mask;
    logic [7:0]         thresh;
    logic               cpu_ack;
    logic               cpu_eoi;
    logic               irq_req;
    logic [7:0]         irq_id;
    logic [7:0]         irq_prio;
    logic               in_service;
    logic [7:0]         svc_id;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output irq_src, en_mask, thresh, cpu_ack, cpu_eoi,
        input  irq_req, irq_id, irq_prio, in_service, svc_id, pending
    );

    modport slave (
        input  irq_src, en_mask, thresh, cpu_ack, cpu_eoi,
        output irq_req, irq_id, irq_prio, in_service, svc_id, pending
    );
endinterface

// File: rtl/intr_arbiter.sv
// Edge-triggered interrupt arbiter: per-source pending cells, registered
// lowest-index arbitration, and an IDLE/REQ/SERVICE claim FSM.
module intr_src_cell (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic clr,
    output logic pend
);
    logic src_q;

    // src_q resets to 0 so a line held high through reset reads as a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            src_q <= src;
            pend  <= (pend & ~clr) | (src & ~src_q);
        end
    end
endmodule

module intr_arbiter #(
    parameter int NUM_SRC = 16
) (
    input  logic           clk,
    input  logic           rst,
    intr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] pend, elig, clr;
    logic               best_valid, best_valid_c;
    logic [7:0]         best_id, best_id_c;
    logic [7:0]         irq_id_q, irq_prio_q, svc_id_q;
    logic               best_live, cur_en;
    logic               ack_clr, latch_req, latch_svc;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        intr_src_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .src  (bus.irq_src[i]),
            .clr  (clr[i]),
            .pend (pend[i])
        );
        assign clr[i] = ack_clr && (irq_id_q == 8'(i));
    end

    assign elig = pend & bus.en_mask;

    always_comb begin
        best_valid_c = 1'b0;
        best_id_c    = 8'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                best_valid_c = 1'b1;
                best_id_c    = 8'(i);
            end
        end
    end

    // The registered winner may be stale; recheck it against live pending/mask.
    always_comb begin
        best_live = 1'b0;
        cur_en    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (best_id == 8'(i))
                best_live = pend[i] & bus.en_mask[i];
            if (irq_id_q == 8'(i))
                cur_en = bus.en_mask[i];
        end
    end

    always_comb begin
        state_nxt = state;
        ack_clr   = 1'b0;
        latch_req = 1'b0;
        latch_svc = 1'b0;
        case (state)
            IDLE: begin
                if (best_valid && best_live && ((8'd255 - best_id) > bus.thresh)) begin
                    state_nxt = REQ;
                    latch_req = 1'b1;
                end
            end
            REQ: begin
                if (bus.cpu_ack) begin
                    state_nxt = SERVICE;
                    ack_clr   = 1'b1;
                    latch_svc = 1'b1;
                end else if (!cur_en || (irq_prio_q <= bus.thresh)) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (bus.cpu_eoi)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            best_valid <= 1'b0;
            best_id    <= 8'd0;
            irq_id_q   <= 8'd0;
            irq_prio_q <= 8'd0;
            svc_id_q   <= 8'd0;
        end else begin
            state      <= state_nxt;
            best_valid <= best_valid_c;
            best_id    <= best_id_c;
            if (latch_req) begin
                irq_id_q   <= best_id;
                irq_prio_q <= 8'd255 - best_id;
            end
            if (latch_svc)
                svc_id_q <= irq_id_q;
        end
    end

    assign bus.irq_req    = (state == REQ);
    assign bus.in_service = (state == SERVICE);
    assign bus.irq_id     = irq_id_q;
    assign bus.irq_prio   = irq_prio_q;
    assign bus.svc_id     = svc_id_q;
    assign bus.pending    = pend;
endmodule

// File: tb/tb_intr_arbiter.sv
// Scoreboard bench for intr_arbiter: each cycle pushes the expected outputs,
// then pops and compares them after the clock edge.
module tb_intr_arbiter;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    intr_arbiter_if #(.NUM_SRC(N)) bus ();

    intr_arbiter #(.NUM_SRC(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       tag;
        logic        req;
        logic [7:0]  id;
        logic [7:0]  prio;
        logic        insvc;
        logic [7:0]  svc;
        logic [15:0] pend;
        bit          full;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Push expectation, advance one edge, pop and compare.
    task automatic cyc(input string tag, input logic req, input logic [7:0] id,
                       input logic insvc, input logic [7:0] svc,
                       input logic [15:0] pend, input bit full);
        exp_t e;
        e.tag = tag; e.req = req; e.id = id; e.prio = 8'd255 - id;
        e.insvc = insvc; e.svc = svc; e.pend = pend; e.full = full;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".req"}, 32'(bus.irq_req), 32'(e.req));
        chk({e.tag, ".insvc"}, 32'(bus.in_service), 32'(e.insvc));
        chk({e.tag, ".pend"}, 32'(bus.pending), 32'(e.pend));
        if (e.full) begin
            chk({e.tag, ".id"}, 32'(bus.irq_id), 32'd0);
            chk({e.tag, ".prio"}, 32'(bus.irq_prio), 32'd0);
            chk({e.tag, ".svc"}, 32'(bus.svc_id), 32'd0);
        end else begin
            if (e.req) begin
                chk({e.tag, ".id"}, 32'(bus.irq_id), 32'(e.id));
                chk({e.tag, ".prio"}, 32'(bus.irq_prio), 32'(e.prio));
            end
            if (e.insvc)
                chk({e.tag, ".svc"}, 32'(bus.svc_id), 32'(e.svc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.irq_src = '0;
        bus.en_mask = '1;
        bus.thresh  = 8'd0;
        bus.cpu_ack = 1'b0;
        bus.cpu_eoi = 1'b0;
        @(posedge clk); #1;
        cyc("reset", 0, 0, 0, 0, 16'h0000, 1);
        rst = 1'b0;

        // Single source 5: pending after k, request after k+2.
        bus.irq_src[5] = 1'b1;
        cyc("s5.k",   0, 0, 0, 0, 16'h0020, 0);
        cyc("s5.k1",  0, 0, 0, 0, 16'h0020, 0);
        cyc("s5.k2",  1, 5, 0, 0, 16'h0020, 0);
        bus.cpu_ack = 1'b1;
        cyc("s5.ack", 0, 0, 1, 5, 16'h0000, 0);
        bus.cpu_ack = 1'b0; bus.irq_src[5] = 1'b0;
        cyc("s5.svc", 0, 0, 1, 5, 16'h0000, 0);
        bus.cpu_eoi = 1'b1;
        cyc("s5.eoi", 0, 0, 0, 0, 16'h0000, 0);
        bus.cpu_eoi = 1'b0;

        // Sources 3 and 9 together: 3 wins, 9 follows after EOI.
        bus.irq_src[3] = 1'b1; bus.irq_src[9] = 1'b1;
        cyc("d.k",    0, 0, 0, 0, 16'h0208, 0);
        cyc("d.k1",   0, 0, 0, 0, 16'h0208, 0);
        cyc("d.k2",   1, 3, 0, 0, 16'h0208, 0);
        bus.cpu_ack = 1'b1;
        cyc("d.ack3", 0, 0, 1, 3, 16'h0200, 0);
        bus.cpu_ack = 1'b0;
        cyc("d.svc3", 0, 0, 1, 3, 16'h0200, 0);
        bus.cpu_eoi = 1'b1;
        cyc("d.eoi3", 0, 0, 0, 0, 16'h0200, 0);
        bus.cpu_eoi = 1'b0;
        cyc("d.req9", 1, 9, 0, 0, 16'h0200, 0);
        bus.cpu_ack = 1'b1;
        cyc("d.ack9", 0, 0, 1, 9, 16'h0000, 0);
        bus.cpu_ack = 1'b0; bus.irq_src[3] = 1'b0; bus.irq_src[9] = 1'b0;
        bus.cpu_eoi = 1'b1;
        cyc("d.eoi9", 0, 0, 0, 0, 16'h0000, 0);
        bus.cpu_eoi = 1'b0;

        // Source 4: withdrawal by mask, re-request, then ack racing a mask clear.
        bus.irq_src[4] = 1'b1;
        cyc("m.k",    0, 0, 0, 0, 16'h0010, 0);
        cyc("m.k1",   0, 0, 0, 0, 16'h0010, 0);
        cyc("m.k2",   1, 4, 0, 0, 16'h0010, 0);
        bus.en_mask[4] = 1'b0;
        cyc("m.wd",   0, 0, 0, 0, 16'h0010, 0);
        cyc("m.hold", 0, 0, 0, 0, 16'h0010, 0);
        bus.en_mask[4] = 1'b1;
        cyc("m.re0",  0, 0, 0, 0, 16'h0010, 0);
        cyc("m.re1",  1, 4, 0, 0, 16'h0010, 0);
        bus.en_mask[4] = 1'b0; bus.cpu_ack = 1'b1;
        cyc("m.race", 0, 0, 1, 4, 16'h0000, 0);
        bus.en_mask[4] = 1'b1; bus.cpu_ack = 1'b0; bus.irq_src[4] = 1'b0;
        bus.cpu_eoi = 1'b1;
        cyc("m.eoi",  0, 0, 0, 0, 16'h0000, 0);
        cyc("m.stray_eoi", 0, 0, 0, 0, 16'h0000, 0);
        bus.cpu_eoi = 1'b0; bus.cpu_ack = 1'b1;
        cyc("m.stray_ack", 0, 0, 0, 0, 16'h0000, 0);
        bus.cpu_ack = 1'b0;

        // Threshold: 250 blocks source 6 but passes source 2; 255 blocks all.
        bus.thresh = 8'd250;
        bus.irq_src[6] = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc("t.blk6", 0, 0, 0, 0, 16'h0040, 0);
        bus.irq_src[2] = 1'b1;
        cyc("t.k",    0, 0, 0, 0, 16'h0044, 0);
        cyc("t.k1",   0, 0, 0, 0, 16'h0044, 0);
        cyc("t.k2",   1, 2, 0, 0, 16'h0044, 0);
        bus.cpu_ack = 1'b1;
        cyc("t.ack2", 0, 0, 1, 2, 16'h0040, 0);
        bus.cpu_ack = 1'b0; bus.cpu_eoi = 1'b1;
        cyc("t.eoi2", 0, 0, 0, 0, 16'h0040, 0);
        bus.cpu_eoi = 1'b0;
        cyc("t.still", 0, 0, 0, 0, 16'h0040, 0);
        bus.thresh = 8'd0;
        cyc("t.req6", 1, 6, 0, 0, 16'h0040, 0);
        bus.thresh = 8'd255;
        cyc("t.wd255", 0, 0, 0, 0, 16'h0040, 0);
        cyc("t.blk255", 0, 0, 0, 0, 16'h0040, 0);
        cyc("t.blk255b", 0, 0, 0, 0, 16'h0040, 0);
        bus.thresh = 8'd0;
        cyc("t.req6b", 1, 6, 0, 0, 16'h0040, 0);
        bus.cpu_ack = 1'b1;
        cyc("t.ack6", 0, 0, 1, 6, 16'h0000, 0);
        bus.cpu_ack = 1'b0; bus.irq_src[6] = 1'b0; bus.irq_src[2] = 1'b0;
        bus.cpu_eoi = 1'b1;
        cyc("t.eoi6", 0, 0, 0, 0, 16'h0000, 0);
        bus.cpu_eoi = 1'b0;

        // Source 1: no preemption by source 0, then reset in SERVICE with 1 held.
        bus.irq_src[1] = 1'b1;
        cyc("r.k",    0, 0, 0, 0, 16'h0002, 0);
        cyc("r.k1",   0, 0, 0, 0, 16'h0002, 0);
        cyc("r.k2",   1, 1, 0, 0, 16'h0002, 0);
        bus.irq_src[0] = 1'b1;
        cyc("r.nopre", 1, 1, 0, 0, 16'h0003, 0);
        bus.cpu_ack = 1'b1;
        cyc("r.ack1", 0, 0, 1, 1, 16'h0001, 0);
        bus.cpu_ack = 1'b0; bus.irq_src[0] = 1'b0;
        rst = 1'b1;
        cyc("r.rst",  0, 0, 0, 0, 16'h0000, 1);
        rst = 1'b0;
        cyc("r.p1",   0, 0, 0, 0, 16'h0002, 0);
        cyc("r.p1b",  0, 0, 0, 0, 16'h0002, 0);
        cyc("r.req1", 1, 1, 0, 0, 16'h0002, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
